path_walker: RTL

- Downstream consumer of the direction stack: requests a read-out, takes the stored 2-bit move codes in replay order, and walks a cursor across the maze grid from a fixed start cell.
- Emits one registered (x, y) coordinate per accepted move.
- Flags any move that leaves the grid.
- Feeds the result/display stage with a cell-by-cell path.

---
 rtl/path_walker_pkg.sv | 19 +
 rtl/path_walker_coord_step.sv | 37 +++
 rtl/path_walker.sv | 126 ++++++++++++
 3 files changed

// File: rtl/path_walker_pkg.sv
// Shared maze definitions: direction codes, walker FSM states and the default grid width.
package path_walker_pkg;

    localparam int unsigned COORD_W = 4;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WALK,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/path_walker_coord_step.sv
// Combinational next-cell computation with grid bounds check; shared with the solver.
module path_walker_coord_step #(
    parameter int unsigned DIR_W   = 2,
    parameter int unsigned COORD_W = path_walker_pkg::COORD_W
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [DIR_W-1:0]   dir,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic               oob
);
    import path_walker_pkg::*;

    localparam logic [COORD_W:0] One    = {{COORD_W{1'b0}}, 1'b1};
    localparam logic [COORD_W:0] MaxPos = {1'b0, {COORD_W{1'b1}}};

    // One extra bit so that both 0-1 and max+1 land above MaxPos.
    logic [COORD_W:0] wx;
    logic [COORD_W:0] wy;

    always_comb begin
        wx = {1'b0, x};
        wy = {1'b0, y};
        unique case (dir)
            DIR_UP:    wy = {1'b0, y} - One;
            DIR_RIGHT: wx = {1'b0, x} + One;
            DIR_LEFT:  wx = {1'b0, x} - One;
            DIR_DOWN:  wy = {1'b0, y} + One;
        endcase
    end

    assign oob = (wx > MaxPos) || (wy > MaxPos);
    assign nx  = wx[COORD_W-1:0];
    assign ny  = wy[COORD_W-1:0];

endmodule

// File: rtl/path_walker.sv
// Replays stored move codes from the direction stack, walking a cursor over the grid.
module path_walker #(
    parameter int unsigned           DIR_W     = 2,
    parameter int unsigned           COORD_W   = path_walker_pkg::COORD_W,
    parameter logic [COORD_W-1:0]    START_X   = '0,
    parameter logic [COORD_W-1:0]    START_Y   = '0,
    parameter int unsigned           MAX_STEPS = 256,
    localparam int unsigned          CNT_W     = $clog2(MAX_STEPS) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               dir_valid,
    input  logic [DIR_W-1:0]   dir_in,
    input  logic               stream_done,
    output logic               req_read,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               step_valid,
    output logic [CNT_W-1:0]   step_count,
    output logic               busy,
    output logic               done,
    output logic               error
);
    import path_walker_pkg::*;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               step_q, step_d;

    logic [COORD_W-1:0] nx, ny;
    logic               oob;

    path_walker_coord_step #(
        .DIR_W  (DIR_W),
        .COORD_W(COORD_W)
    ) u_coord_step (
        .x  (x_q),
        .y  (y_q),
        .dir(dir_in),
        .nx (nx),
        .ny (ny),
        .oob(oob)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            error_q <= error_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        error_d = error_q;
        step_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    x_d     = START_X;
                    y_d     = START_Y;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: state_d = WALK;
            WALK: begin
                // A rejected move takes priority over a coincident stream_done.
                if (dir_valid && (oob || cnt_q == MaxCnt)) begin
                    error_d = 1'b1;
                    state_d = ERR;
                end else begin
                    if (dir_valid) begin
                        x_d    = nx;
                        y_d    = ny;
                        cnt_d  = cnt_q + 1'b1;
                        step_d = 1'b1;
                    end
                    if (stream_done) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_read = (state_q == REQ);
        busy     = (state_q == REQ) || (state_q == WALK);
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign step_count = cnt_q;
    assign step_valid = step_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
